// File: rtl/text_grid_arbiter_pkg.sv
// Shared constants and types for the text-grid BRAM arbiter.
// Grid geometry (64x64 characters) sets the BRAM address width; the BRAM is
// used in its registered-output mode, giving a fixed two-cycle read latency.
package text_grid_arbiter_pkg;

    localparam int unsigned SCREEN_WIDTH           = 64;
    localparam int unsigned SCREEN_HEIGHT          = 64;
    localparam int unsigned GRID_ADDR_WIDTH        = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);
    localparam int unsigned GRID_CHAR_WIDTH        = 8;
    localparam int unsigned TEXT_BRAM_READ_LATENCY = 2;
    localparam int unsigned STALL_COUNT_WIDTH      = 16;

    // Which requester owns the BRAM port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } grant_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_COUNT_WIDTH-1:0] sat_inc(
        input logic [STALL_COUNT_WIDTH-1:0] value
    );
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/text_grid_arbiter_valid_delay_line.sv
// N-stage valid shift register with asynchronous active-high reset.
// Ports:
//   clk_in    - clock
//   rst_in    - asynchronous active-high reset, clears every stage
//   valid_in  - bit entering stage 0
//   valid_out - last stage, valid_in delayed by DEPTH cycles
module valid_delay_line
    import text_grid_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = TEXT_BRAM_READ_LATENCY
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic valid_in,
    output logic valid_out
);

    logic [DEPTH-1:0] r_stages;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    r_stages <= '0;
                end else begin
                    r_stages <= valid_in;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    r_stages <= '0;
                end else begin
                    r_stages <= {r_stages[DEPTH-2:0], valid_in};
                end
            end
        end
    endgenerate

    assign valid_out = r_stages[DEPTH-1];

endmodule

// File: rtl/text_grid_arbiter.sv
// Arbiter sharing the single-port text-grid BRAM between the terminal
// controller (writes, through a 1-entry buffer) and the assembler line feeder
// (reads). Writes win by default; after STARVE_LIMIT consecutive write grants
// against a pending read, the read is granted unless it targets the buffered
// write address, in which case the write drains first so the read sees it.
// Ports:
//   clk_in, rst_in         - clock, asynchronous active-high reset
//   wr_valid_in/addr/data  - write request;  wr_ready_out accepts it
//   rd_valid_in/addr       - read request;   rd_ready_out accepts it
//   rd_data_out            - BRAM read data passthrough
//   rd_data_valid_out      - high READ_LATENCY cycles after a read handshake
//   ram_addr/din/we_out    - BRAM port;      ram_dout_in is its read data
//   stall_count_out        - saturating count of cycles a read waited
module text_grid_arbiter
    import text_grid_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = GRID_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = GRID_CHAR_WIDTH,
    parameter int unsigned READ_LATENCY = TEXT_BRAM_READ_LATENCY,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         wr_valid_in,
    input  logic [ADDR_WIDTH-1:0]        wr_addr_in,
    input  logic [DATA_WIDTH-1:0]        wr_data_in,
    output logic                         wr_ready_out,
    input  logic                         rd_valid_in,
    input  logic [ADDR_WIDTH-1:0]        rd_addr_in,
    output logic                         rd_ready_out,
    output logic [DATA_WIDTH-1:0]        rd_data_out,
    output logic                         rd_data_valid_out,
    output logic [ADDR_WIDTH-1:0]        ram_addr_out,
    output logic [DATA_WIDTH-1:0]        ram_din_out,
    output logic                         ram_we_out,
    input  logic [DATA_WIDTH-1:0]        ram_dout_in,
    output logic [STALL_COUNT_WIDTH-1:0] stall_count_out
);

    localparam int unsigned STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);

    logic                         r_wbuf_valid;
    logic [ADDR_WIDTH-1:0]        r_wbuf_addr;
    logic [DATA_WIDTH-1:0]        r_wbuf_data;
    logic [STARVE_WIDTH-1:0]      r_starve_cnt;
    logic [STALL_COUNT_WIDTH-1:0] r_stall_count;

    grant_e w_grant;
    logic   w_hazard;
    logic   w_starved;
    logic   w_grant_rd;
    logic   w_grant_wr;
    logic   w_wr_hs;

    always_comb begin
        w_hazard  = r_wbuf_valid && rd_valid_in && (rd_addr_in == r_wbuf_addr);
        w_starved = (r_starve_cnt == STARVE_WIDTH'(STARVE_LIMIT));
        w_grant   = GNT_NONE;
        // A starved read may overtake the buffer, but never a write to its own address.
        if (rd_valid_in && (!r_wbuf_valid || (w_starved && !w_hazard))) begin
            w_grant = GNT_RD;
        end else if (r_wbuf_valid) begin
            w_grant = GNT_WR;
        end
    end

    assign w_grant_rd = (w_grant == GNT_RD);
    assign w_grant_wr = (w_grant == GNT_WR);

    // Draining the buffer this cycle frees it for a new write in the same cycle.
    assign wr_ready_out = !r_wbuf_valid || w_grant_wr;
    assign w_wr_hs      = wr_valid_in && wr_ready_out;

    assign rd_ready_out    = w_grant_rd;
    assign ram_we_out      = w_grant_wr;
    assign ram_addr_out    = w_grant_wr ? r_wbuf_addr : rd_addr_in;
    assign ram_din_out     = r_wbuf_data;
    assign rd_data_out     = ram_dout_in;
    assign stall_count_out = r_stall_count;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wbuf_valid <= 1'b0;
            r_wbuf_addr  <= '0;
            r_wbuf_data  <= '0;
        end else if (w_wr_hs) begin
            r_wbuf_valid <= 1'b1;
            r_wbuf_addr  <= wr_addr_in;
            r_wbuf_data  <= wr_data_in;
        end else if (w_grant_wr) begin
            r_wbuf_valid <= 1'b0;
        end
    end

    // A pending read that is not granted implies a write grant, so the
    // increment branch only needs the saturation test.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_starve_cnt <= '0;
        end else if (w_grant_rd || !rd_valid_in) begin
            r_starve_cnt <= '0;
        end else if (w_grant_wr && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_stall_count <= '0;
        end else if (rd_valid_in && !w_grant_rd) begin
            r_stall_count <= sat_inc(r_stall_count);
        end
    end

    valid_delay_line #(
        .DEPTH (READ_LATENCY)
    ) u_rsp_valid (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .valid_in  (w_grant_rd),
        .valid_out (rd_data_valid_out)
    );

endmodule

// File: tb/tb_text_grid_arbiter.sv
module tb_text_grid_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        wr_valid_in;
    logic [11:0] wr_addr_in;
    logic [7:0]  wr_data_in;
    logic        wr_ready_out;
    logic        rd_valid_in;
    logic [11:0] rd_addr_in;
    logic        rd_ready_out;
    logic [7:0]  rd_data_out;
    logic        rd_data_valid_out;
    logic [11:0] ram_addr_out;
    logic [7:0]  ram_din_out;
    logic        ram_we_out;
    logic [7:0]  ram_dout_in;
    logic [15:0] stall_count_out;

    text_grid_arbiter #(
        .ADDR_WIDTH   (12),
        .DATA_WIDTH   (8),
        .READ_LATENCY (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .wr_valid_in       (wr_valid_in),
        .wr_addr_in        (wr_addr_in),
        .wr_data_in        (wr_data_in),
        .wr_ready_out      (wr_ready_out),
        .rd_valid_in       (rd_valid_in),
        .rd_addr_in        (rd_addr_in),
        .rd_ready_out      (rd_ready_out),
        .rd_data_out       (rd_data_out),
        .rd_data_valid_out (rd_data_valid_out),
        .ram_addr_out      (ram_addr_out),
        .ram_din_out       (ram_din_out),
        .ram_we_out        (ram_we_out),
        .ram_dout_in       (ram_dout_in),
        .stall_count_out   (stall_count_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] init_char(input int i);
        return 8'(i) + 8'h20;
    endfunction

    // Read-first BRAM with registered address and registered output (2 cycles).
    logic [7:0] mem [0:4095];
    logic [7:0] r_q1, r_q2;
    bit         mem_ready = 1'b0;
    always @(posedge clk_in) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] = init_char(i);
            mem_ready = 1'b1;
        end
        r_q1 <= mem[ram_addr_out];
        if (ram_we_out) mem[ram_addr_out] <= ram_din_out;
        r_q2 <= r_q1;
    end
    assign ram_dout_in = r_q2;

    typedef struct packed {
        logic [7:0]  data;
        logic [31:0] due;
    } rd_exp_t;
    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    rd_exp_t    rd_q[$];
    wr_exp_t    wr_q[$];
    logic [7:0] golden [0:4095];
    int         n_pass  = 0;
    int         n_total = 0;
    int         cyc     = 0;
    logic       wr_hs, rd_hs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic wv, input logic [11:0] wa, input logic [7:0] wd,
                         input logic rv, input logic [11:0] ra);
        wr_valid_in = wv;
        wr_addr_in  = wa;
        wr_data_in  = wd;
        rd_valid_in = rv;
        rd_addr_in  = ra;
        #1;
    endtask

    // Scoreboard step: called after drive() while outputs are settled.
    task automatic cycle();
        rd_exp_t re;
        wr_exp_t we;
        if (rd_data_valid_out) begin
            if (rd_q.size() > 0) begin
                re = rd_q.pop_front();
                check("rd_data", 32'(rd_data_out), 32'(re.data));
                check("rd_latency", 32'(cyc), re.due);
            end else begin
                check("rd_unexpected", 32'(rd_data_valid_out), 32'd0);
            end
        end
        if (ram_we_out) begin
            if (wr_q.size() > 0) begin
                we = wr_q.pop_front();
                check("ram_wr_addr", 32'(ram_addr_out), 32'(we.addr));
                check("ram_wr_data", 32'(ram_din_out), 32'(we.data));
            end else begin
                check("wr_unexpected", 32'(ram_we_out), 32'd0);
            end
        end
        rd_hs = rd_valid_in && rd_ready_out;
        wr_hs = wr_valid_in && wr_ready_out;
        // Read expectation is taken before a same-cycle write updates the model.
        if (rd_hs) rd_q.push_back('{golden[rd_addr_in], 32'(cyc + 2)});
        if (wr_hs) begin
            wr_q.push_back('{wr_addr_in, wr_data_in});
            golden[wr_addr_in] = wr_data_in;
        end
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && (rd_q.size() + wr_q.size()) != 0; k++) begin
            drive(1'b0, 12'h0, 8'h0, 1'b0, 12'h0);
            cycle();
        end
        check("drain_empty", 32'(rd_q.size() + wr_q.size()), 32'd0);
    endtask

    initial begin : stim
        logic [11:0] hz_addr [5];
        logic [7:0]  hz_data [5];
        logic [7:0]  saved;
        int          n;

        for (int i = 0; i < 4096; i++) golden[i] = init_char(i);
        rst_in = 1'b1;
        drive(1'b0, 12'h0, 8'h0, 1'b0, 12'h2A5);
        @(negedge clk_in);
        @(negedge clk_in);
        #1;
        check("rst_wr_ready", 32'(wr_ready_out), 32'd1);
        check("rst_rd_ready", 32'(rd_ready_out), 32'd0);
        check("rst_ram_we", 32'(ram_we_out), 32'd0);
        check("rst_rd_valid", 32'(rd_data_valid_out), 32'd0);
        check("rst_stall", 32'(stall_count_out), 32'd0);
        check("rst_ram_addr", 32'(ram_addr_out), 32'h2A5);
        check("rst_ram_din", 32'(ram_din_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Read only
        drive(1'b0, 12'h0, 8'h0, 1'b1, 12'h041);
        check("ro_rd_ready", 32'(rd_ready_out), 32'd1);
        check("ro_ram_addr", 32'(ram_addr_out), 32'h041);
        cycle();
        drain();
        check("ro_stall", 32'(stall_count_out), 32'd0);

        // Three back-to-back writes
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, 12'(i), 8'h61 + 8'(i), 1'b0, 12'h0);
            else       drive(1'b0, 12'h0, 8'h0, 1'b0, 12'h0);
            if (i < 3) check("wr3_ready", 32'(wr_ready_out), 32'd1);
            check("wr3_we", 32'(ram_we_out), (i >= 1 && i <= 3) ? 32'd1 : 32'd0);
            cycle();
        end
        drain();

        // Starvation: 4 write grants then one read grant, repeating
        n = 0;
        drive(1'b1, 12'h300, 8'h41, 1'b0, 12'h0);
        cycle();
        if (wr_hs) n++;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 12'h300 + 12'(n), 8'h41 + 8'(n), 1'b1, 12'h200);
            check("stv_rd_ready", 32'(rd_ready_out), (i % 5 == 4) ? 32'd1 : 32'd0);
            check("stv_ram_we", 32'(ram_we_out), (i % 5 == 4) ? 32'd0 : 32'd1);
            check("stv_wr_ready", 32'(wr_ready_out), (i % 5 == 4) ? 32'd0 : 32'd1);
            if (i == 5) check("stv_stall_4", 32'(stall_count_out), 32'd4);
            cycle();
            if (wr_hs) n++;
        end
        drive(1'b0, 12'h0, 8'h0, 1'b0, 12'h0);
        check("stv_stall_8", 32'(stall_count_out), 32'd8);
        drain();

        // Hazard: buffered write to 0x100 must land before the read of 0x100
        hz_addr = '{12'h180, 12'h181, 12'h182, 12'h183, 12'h100};
        hz_data = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h78};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, hz_addr[i], hz_data[i], i >= 1, 12'h100);
            check("hz_fill_we", 32'(ram_we_out), (i >= 1) ? 32'd1 : 32'd0);
            check("hz_fill_rd_ready", 32'(rd_ready_out), 32'd0);
            cycle();
        end
        drive(1'b0, 12'h0, 8'h0, 1'b1, 12'h100);
        check("hz_block_rd", 32'(rd_ready_out), 32'd0);
        check("hz_wr_first", 32'(ram_we_out), 32'd1);
        check("hz_wr_addr", 32'(ram_addr_out), 32'h100);
        check("hz_wr_din", 32'(ram_din_out), 32'h78);
        cycle();
        drive(1'b0, 12'h0, 8'h0, 1'b1, 12'h100);
        check("hz_rd_grant", 32'(rd_ready_out), 32'd1);
        check("hz_rd_we", 32'(ram_we_out), 32'd0);
        cycle();
        drain();

        // Simultaneous write and read with an empty buffer
        drive(1'b1, 12'h010, 8'h7A, 1'b1, 12'h020);
        check("sim_rd_ready", 32'(rd_ready_out), 32'd1);
        check("sim_wr_ready", 32'(wr_ready_out), 32'd1);
        check("sim_we_t", 32'(ram_we_out), 32'd0);
        cycle();
        drive(1'b0, 12'h0, 8'h0, 1'b0, 12'h0);
        check("sim_we_t1", 32'(ram_we_out), 32'd1);
        check("sim_addr_t1", 32'(ram_addr_out), 32'h010);
        cycle();
        drain();

        // Async reset between read handshake and response; buffered write dropped
        saved = golden[12'h7FF];
        drive(1'b1, 12'h7FF, 8'h99, 1'b1, 12'h041);
        check("rr_rd_ready", 32'(rd_ready_out), 32'd1);
        cycle();
        rst_in = 1'b1;
        rd_q.delete();
        wr_q.delete();
        golden[12'h7FF] = saved;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 12'h0, 8'h0, 1'b0, 12'h7AB);
            check("rr_rd_valid", 32'(rd_data_valid_out), 32'd0);
            check("rr_ram_we", 32'(ram_we_out), 32'd0);
            check("rr_ram_addr", 32'(ram_addr_out), 32'h7AB);
            check("rr_stall", 32'(stall_count_out), 32'd0);
            check("rr_ram_din", 32'(ram_din_out), 32'd0);
            cycle();
        end
        rst_in = 1'b0;
        drive(1'b0, 12'h0, 8'h0, 1'b0, 12'h0);
        check("rr_wr_ready", 32'(wr_ready_out), 32'd1);
        check("rr_rd_valid_rel", 32'(rd_data_valid_out), 32'd0);
        cycle();
        drive(1'b0, 12'h0, 8'h0, 1'b1, 12'h7FF);
        check("rr_post_rd_ready", 32'(rd_ready_out), 32'd1);
        cycle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/text_grid_arbiter.md
Name: text_grid_arbiter

Overview:
Shares the single-port 8-bit text-grid BRAM (64x64 chars) between two requesters.
- The terminal controller is the write-only requester.
- The assembler line feeder is the read-only requester.
Writes pass through a 1-entry buffer. Writes normally have priority; a starvation limit guarantees the reader progress. A read-after-write hazard guard keeps reads coherent, and read responses are tagged with a fixed-latency valid pipeline.

Parameters:
ADDR_WIDTH, 12, grid address width (64*64 entries)
DATA_WIDTH, 8, character width
READ_LATENCY, 2, BRAM read latency in cycles (HIGH_PERFORMANCE mode)
STARVE_LIMIT, 4, max consecutive write grants while a read is pending

Ports:
clk_in  input  1  pixel clock
rst_in  input  1  asynchronous active-high reset
wr_valid_in  input  1  terminal write request
wr_addr_in  input  ADDR_WIDTH  write address
wr_data_in  input  DATA_WIDTH  write character
wr_ready_out  output  1  write accepted when wr_valid_in && wr_ready_out
rd_valid_in  input  1  assembler read request
rd_addr_in  input  ADDR_WIDTH  read address
rd_ready_out  output  1  read accepted when rd_valid_in && rd_ready_out
rd_data_out  output  DATA_WIDTH  read character (ram_dout_in passthrough)
rd_data_valid_out  output  1  rd_data_out valid
ram_addr_out  output  ADDR_WIDTH  BRAM address
ram_din_out  output  DATA_WIDTH  BRAM write data
ram_we_out  output  1  BRAM write enable
ram_dout_in  input  DATA_WIDTH  BRAM read data
stall_count_out  output  16  saturating count of cycles with a pending, ungranted read

Behaviour:
Clock and reset:
- Single clock, clk_in.
- rst_in is asynchronous and active-high.
- Reset clears wbuf_valid, starve_cnt, the response valid pipeline and stall_count_out (all to 0).
- Reset mid-operation drops in-flight read responses: rd_data_valid_out=0 from the reset edge. A buffered write is discarded.

Write buffer (wbuf_valid, wbuf_addr, wbuf_data):
- wr_ready_out = !wbuf_valid || grant_wr (combinational), giving 1 write/cycle sustained throughput.
- On a write handshake, wbuf loads wr_addr_in/wr_data_in and wbuf_valid=1.
- Otherwise, grant_wr clears wbuf_valid.
- Minimum write latency: handshake in cycle t -> ram_we_out in cycle t+1.

Arbitration (combinational each cycle):
- hazard = wbuf_valid && rd_valid_in && (rd_addr_in == wbuf_addr)
- grant_rd = rd_valid_in && (!wbuf_valid || (starve_cnt == STARVE_LIMIT && !hazard))
- grant_wr = wbuf_valid && !grant_rd
- rd_ready_out = grant_rd
- ram_we_out = grant_wr
- ram_addr_out = grant_wr ? wbuf_addr : rd_addr_in
- ram_din_out = wbuf_data

starve_cnt (width clog2(STARVE_LIMIT+1)):
- Increments, saturating at STARVE_LIMIT, when grant_wr && rd_valid_in.
- Clears to 0 on grant_rd or when !rd_valid_in.

Hazard:
- A read that hits the buffered write address is never granted ahead of that write.
- The read then returns the newly written data (BRAM is read-first, but the write lands in an earlier cycle).

Read response:
- Shift register of READ_LATENCY valid bits; grant_rd enters stage 0.
- rd_data_valid_out = last stage, i.e. exactly READ_LATENCY cycles after the read handshake.
- Back-to-back reads give back-to-back valids, in order.

stall_count_out:
- +1 on each cycle with rd_valid_in && !grant_rd.
- Saturates at 16'hFFFF.

Simultaneous new write and read with an empty wbuf:
- The read is granted.
- The write is accepted into wbuf in the same cycle.

Decomposition:
- Shared constants package: GRID_ADDR_WIDTH and GRID_CHAR_WIDTH (derived from SCREEN_WIDTH/SCREEN_HEIGHT = 64), and TEXT_BRAM_READ_LATENCY = 2.
- One natural sub-module, valid_delay_line: a parameterized N-stage valid shift register with async reset. It is used for the read response pipeline.

Test Plan:
- Read only: rd_valid_in=1, addr 0x041, RAM holds 0x61 -> rd_ready_out=1 same cycle; rd_data_valid_out=1 with rd_data_out=0x61 exactly 2 cycles later.
- Write only, 3 writes to consecutive cycles (0x000:'a', 0x001:'b', 0x002:'c') -> wr_ready_out stays 1; ram_we_out high 3 consecutive cycles starting one cycle after the first handshake, with correct addr/data.
- Starvation: continuous writes plus rd_valid_in held -> exactly 4 write grants, then 1 read grant; stall_count_out=4 after it; pattern repeats.
- Hazard: write 0x100:'x' buffered, read 0x100 with starve_cnt=STARVE_LIMIT -> write granted first, then read granted; response returns 'x'.
- Simultaneous, empty wbuf: write 0x010:'z' and read 0x020 -> read granted cycle t, write issued cycle t+1; no lost transaction.
- Async reset asserted between a read handshake and its response -> rd_data_valid_out never pulses; all outputs 0 (ram_addr_out = rd_addr_in); wr_ready_out=1 after release.
